// File: rtl/adder_tree_feeder.sv
// Serial-to-parallel front end for a pipelined adder tree: collects one frame of
// signed samples, holds it on the tree operands and returns the tree sum as a single beat.
module adder_tree_feeder #(
  parameter int unsigned INPUT_BW     = 8,
  parameter int unsigned LAYER_NUM    = 3,
  parameter int unsigned ARRAY_SIZE   = 2 ** LAYER_NUM,
  parameter int unsigned OUTPUT_BW    = INPUT_BW + LAYER_NUM,
  parameter int unsigned TREE_LATENCY = 1,
  parameter int unsigned CNT_BW       = $clog2(ARRAY_SIZE + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [INPUT_BW-1:0]  in_data,
  input  logic                        in_last,
  output logic signed [INPUT_BW-1:0]  tree_operands [ARRAY_SIZE-1:0],
  input  logic signed [OUTPUT_BW-1:0] tree_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUTPUT_BW-1:0] out_data,
  output logic [CNT_BW-1:0]           out_count
);

  localparam int unsigned WAIT_BW = 3;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_BW-1:0]  idx;
  logic [WAIT_BW-1:0] wait_cnt;

  logic accept;
  logic frame_close;

  assign accept      = (state == FILL) && in_valid && in_ready;
  assign frame_close = in_last || (idx == CNT_BW'(ARRAY_SIZE - 1));

  // Frame assembly, tree latency wait and result hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      wait_cnt  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
        tree_operands[i] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
              if (idx == CNT_BW'(i)) begin
                tree_operands[i] <= in_data;
              end
            end
            idx <= idx + CNT_BW'(1);
            if (frame_close) begin
              out_count <= idx + CNT_BW'(1);
              wait_cnt  <= '0;
              in_ready  <= 1'b0;
              state     <= WAIT;
            end
          end
        end

        WAIT: begin
          in_ready <= 1'b0;
          if (wait_cnt == WAIT_BW'(TREE_LATENCY)) begin
            out_data  <= tree_result;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + WAIT_BW'(1);
          end
        end

        HOLD: begin
          in_ready <= 1'b0;
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            idx       <= '0;
            in_ready  <= 1'b1;
            state     <= FILL;
            for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
              tree_operands[i] <= '0;
            end
          end
        end

        default: begin
          state    <= FILL;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
